// File: rtl/controlador_compuerta.sv
// Parking-gate access controller: Moore FSM with wrong-PIN alarm and tailgating lock.
// The current FSM state is mirrored on estado_dbg so checkers can bind to it.
module controlador_compuerta #(
    parameter logic [7:0] PIN_CORRECTO = 8'h10,
    parameter int         MAX_INTENTOS = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Vehiculo,
    input  logic       Termino,
    input  logic       enterPin,
    input  logic [7:0] Pin,
    output logic       Cerrado,
    output logic       Abierto,
    output logic       Alarma,
    output logic       Bloqueo,
    output logic [1:0] estado_dbg
);

    typedef enum logic [1:0] {
        CERRADO    = 2'd0,
        ESPERA_PIN = 2'd1,
        ABIERTO    = 2'd2,
        BLOQUEO    = 2'd3
    } estado_t;

    localparam logic [2:0] LIMITE = 3'(MAX_INTENTOS);

    estado_t    state_q, state_d;
    logic [2:0] intentos_q, intentos_d;
    logic       alarma_pin_q, alarma_pin_d;
    logic       enter_q, enter_d;

    logic       enter_ev;
    logic       pin_ok;
    logic [2:0] intentos_inc;

    assign enter_ev     = enterPin & ~enter_q;
    assign pin_ok       = (Pin == PIN_CORRECTO);
    assign intentos_inc = (intentos_q == 3'd7) ? 3'd7 : intentos_q + 3'd1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q      <= CERRADO;
            intentos_q   <= 3'd0;
            alarma_pin_q <= 1'b0;
            enter_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            intentos_q   <= intentos_d;
            alarma_pin_q <= alarma_pin_d;
            enter_q      <= enter_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        intentos_d   = intentos_q;
        alarma_pin_d = alarma_pin_q;
        enter_d      = enterPin;

        unique case (state_q)
            CERRADO: begin
                if (Vehiculo) state_d = ESPERA_PIN;
            end
            ESPERA_PIN: begin
                // A PIN event wins over the vehicle leaving in the same cycle.
                if (enter_ev) begin
                    if (pin_ok) begin
                        state_d      = ABIERTO;
                        intentos_d   = 3'd0;
                        alarma_pin_d = 1'b0;
                    end else begin
                        intentos_d = intentos_inc;
                        if (intentos_inc >= LIMITE) alarma_pin_d = 1'b1;
                    end
                end else if (!Vehiculo) begin
                    state_d = CERRADO;
                end
            end
            ABIERTO: begin
                if (Termino) state_d = Vehiculo ? BLOQUEO : CERRADO;
            end
            BLOQUEO: begin
                if (enter_ev && pin_ok) begin
                    state_d      = ABIERTO;
                    intentos_d   = 3'd0;
                    alarma_pin_d = 1'b0;
                end
            end
            default: state_d = CERRADO;
        endcase
    end

    assign Abierto    = (state_q == ABIERTO);
    assign Cerrado    = ~Abierto;
    assign Bloqueo    = (state_q == BLOQUEO);
    assign Alarma     = alarma_pin_q | Bloqueo;
    assign estado_dbg = state_q;

endmodule

// File: tb/tb_controlador_compuerta.sv
// Bench for controlador_compuerta: directed test-plan scenarios plus random
// traffic, all checked against a behavioural model of the gate.
module tb_controlador_compuerta;

    localparam int MAX_INTENTOS = 3;
    localparam logic [7:0] PIN_OK = 8'h10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vehiculo, termino, enter_pin;
    logic [7:0] pin;
    logic       cerrado, abierto, alarma, bloqueo;
    logic [1:0] estado_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // model: plain booleans and an unbounded wrong-attempt count
    bit m_open, m_locked, m_waiting, m_prev_enter;
    int m_wrong;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    controlador_compuerta #(
        .PIN_CORRECTO(PIN_OK),
        .MAX_INTENTOS(MAX_INTENTOS)
    ) dut (
        .Clk(clk),
        .Reset(rst_n),
        .Vehiculo(vehiculo),
        .Termino(termino),
        .enterPin(enter_pin),
        .Pin(pin),
        .Cerrado(cerrado),
        .Abierto(abierto),
        .Alarma(alarma),
        .Bloqueo(bloqueo),
        .estado_dbg(estado_dbg)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: {Cerrado,Abierto,Alarma,Bloqueo} got %b expected %b at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit ev;
        ev = enter_pin && !m_prev_enter;
        m_prev_enter = enter_pin;
        if (!rst_n) begin
            m_open = 0; m_locked = 0; m_waiting = 0; m_wrong = 0; m_prev_enter = 0;
        end else if (m_locked) begin
            if (ev && pin == PIN_OK) begin
                m_locked = 0; m_open = 1; m_wrong = 0;
            end
        end else if (m_open) begin
            if (termino) begin
                m_open = 0;
                m_locked = vehiculo;
            end
        end else if (m_waiting) begin
            if (ev) begin
                if (pin == PIN_OK) begin
                    m_waiting = 0; m_open = 1; m_wrong = 0;
                end else begin
                    m_wrong++;
                end
            end else if (!vehiculo) begin
                m_waiting = 0;
            end
        end else if (vehiculo) begin
            m_waiting = 1;
        end
        exp_q.push_back({!m_open, m_open, (m_wrong >= MAX_INTENTOS) || m_locked, m_locked});
    endtask

    // One clock: model advances on the same edge, outputs sampled 1 time unit later.
    task automatic step(input string tag);
        logic [3:0] e;
        @(posedge clk);
        model_update();
        #1;
        e = exp_q.pop_front();
        check(tag, {cerrado, abierto, alarma, bloqueo}, e);
    endtask

    // Same as step, plus a check against a hand-derived expectation.
    task automatic step_exp(input string tag, input logic [3:0] exp);
        step({tag, "_model"});
        check(tag, {cerrado, abierto, alarma, bloqueo}, exp);
    endtask

    task automatic pulse(input string tag, input logic [7:0] p, input logic [3:0] exp);
        pin = p; enter_pin = 1'b1;
        step_exp(tag, exp);
        enter_pin = 1'b0;
        step_exp({tag, "_rel"}, exp);
    endtask

    initial begin
        rst_n = 1'b0; vehiculo = 0; termino = 0; enter_pin = 0; pin = 8'h00;
        @(negedge clk);
        step_exp("reset", 4'b1000);
        rst_n = 1'b1;
        step_exp("idle", 4'b1000);

        // normal pass
        vehiculo = 1;
        step_exp("np_wait", 4'b1000);
        pulse("np_open", PIN_OK, 4'b0100);
        vehiculo = 0; termino = 1;
        step_exp("np_close", 4'b1000);
        termino = 0;

        // four wrong, then correct
        vehiculo = 1;
        step_exp("w4_wait", 4'b1000);
        pulse("w4_1", 8'hFF, 4'b1000);
        pulse("w4_2", 8'hFF, 4'b1000);
        pulse("w4_3", 8'hFF, 4'b1010);
        pulse("w4_4", 8'hFF, 4'b1010);
        pulse("w4_ok", PIN_OK, 4'b0100);
        vehiculo = 0; termino = 1;
        step_exp("w4_close", 4'b1000);
        termino = 0;

        // one wrong, then correct
        vehiculo = 1;
        step_exp("w1_wait", 4'b1000);
        pulse("w1_bad", 8'hFF, 4'b1000);
        pulse("w1_ok", PIN_OK, 4'b0100);

        // tailgating
        termino = 1;
        step_exp("tg_lock", 4'b1011);
        termino = 0; vehiculo = 0;
        pulse("tg_bad", 8'h11, 4'b1011);
        pulse("tg_ok", PIN_OK, 4'b0100);
        termino = 1;
        step_exp("tg_close", 4'b1000);
        termino = 0;

        // edge-only enter
        vehiculo = 1;
        step_exp("eo_wait", 4'b1000);
        for (int i = 0; i < 4; i++) begin
            pin = (i < 2) ? 8'h00 : PIN_OK;
            step_exp("eo_noev", 4'b1000);
        end
        enter_pin = 1'b1;
        for (int i = 0; i < 3; i++) step_exp("eo_hold", 4'b0100);
        enter_pin = 1'b0;

        // reset from BLOQUEO, then attempts count from zero
        termino = 1;
        step_exp("rm_lock", 4'b1011);
        termino = 0; rst_n = 1'b0;
        step_exp("rm_reset", 4'b1000);
        rst_n = 1'b1;
        step_exp("rm_wait", 4'b1000);
        pulse("rm_1", 8'hA5, 4'b1000);
        pulse("rm_2", 8'hA5, 4'b1000);
        pulse("rm_3", 8'hA5, 4'b1010);
        rst_n = 1'b0;
        step_exp("rm_reset2", 4'b1000);
        rst_n = 1'b1;

        // random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 60) != 0);
            vehiculo  = ($urandom_range(0, 2) != 0);
            termino   = ($urandom_range(0, 3) == 0);
            enter_pin = ($urandom_range(0, 2) == 0);
            pin       = ($urandom_range(0, 1) == 0) ? PIN_OK : 8'($urandom_range(0, 255));
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
